// File: rtl/fetch_stage_pkg.sv
// Shared constants for the fetch stage: opcode values, FSM state encoding,
// NOP encoding and PC increment, plus small PC alignment helpers.
package fetch_stage_pkg;

  // RV32I base opcode used to build the canonical NOP
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [31:0] INST_NOP = {25'd0, OPC_OP_IMM};

  // Sequential fetch advances one 32-bit word
  localparam logic [31:0] PC_INC = 32'd4;

  // Fetch FSM: FETCH has a request outstanding, HOLD parks behind a stalled decode
  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  // Drop the byte offset so a loaded PC is always word aligned
  function automatic logic [31:0] pc_force_align(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

  // True when a target address is not word aligned
  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_stage_pc_register.sv
// Program counter register for the fetch stage. Asynchronous active-high
// reset to RESET_PC; a redirect load takes precedence over the sequential
// increment, and the increment wraps modulo 2^32.
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_en_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Select next PC: redirect load wins over increment, otherwise hold
  always_comb begin
    pc_d = pc_q;
    if (load_en_i) begin
      pc_d = load_pc_i;
    end else if (inc_en_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  // PC state with asynchronous reset to the boot address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register.
// Issues one request at a time at the current PC, captures the returned
// word into IF/ID, and handles stall, flush and redirect with priority
// reset > redirect > flush > stall > capture.
// Optional feature macro: FETCH_ALIGN_CHECK_EN adds misaligned_fault, which
// latches on a misaligned redirect and blocks fetching until an aligned
// redirect. Without it, redirect targets are forced to word alignment.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        misaligned_fault
`endif
);

  fetch_state_e state_q;
  logic         valid_q;
  logic [31:0]  ifid_pc_q;
  logic [31:0]  ifid_inst_q;
  logic [31:0]  pc;

  logic         fetch_blocked;
  logic         hold_ifid;
  logic         capture;
  logic [31:0]  redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic         fault_q;
  assign fetch_blocked    = fault_q;
  assign redirect_target  = redirect_pc;
  assign misaligned_fault = fault_q;
`else
  assign fetch_blocked    = 1'b0;
  assign redirect_target  = pc_force_align(redirect_pc);
`endif

  // Decide whether this edge captures the returned word into IF/ID
  always_comb begin
    hold_ifid = stall && valid_q;
    capture   = (state_q == ST_FETCH) && imem_ready && !redirect_valid &&
                !flush && !hold_ifid && !fetch_blocked;
  end

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk       (clk),
    .reset     (reset),
    .load_en_i (redirect_valid),
    .load_pc_i (redirect_target),
    .inc_en_i  (capture),
    .pc_o      (pc)
  );

  // Fetch FSM and IF/ID register, evaluated in priority order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      valid_q     <= 1'b0;
      ifid_pc_q   <= 32'h0000_0000;
      ifid_inst_q <= INST_NOP;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else if (redirect_valid) begin
      state_q <= ST_FETCH;
      valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      fault_q <= pc_misaligned(redirect_pc);
`endif
    end else if (flush) begin
      state_q <= ST_FETCH;
      valid_q <= 1'b0;
    end else if (hold_ifid) begin
      state_q <= ST_HOLD;
    end else if (state_q == ST_HOLD) begin
      // Leaving HOLD re-issues the request; no capture on this edge
      state_q <= ST_FETCH;
    end else if (capture) begin
      valid_q     <= 1'b1;
      ifid_pc_q   <= pc;
      ifid_inst_q <= imem_rdata;
    end
  end

  // Request is live only in FETCH, outside reset and outside a fault
  assign imem_req    = !reset && (state_q == ST_FETCH) && !fetch_blocked;
  assign imem_addr   = pc;
  assign if_id_valid = valid_q;
  assign if_id_pc    = ifid_pc_q;
  assign if_id_inst  = ifid_inst_q;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: imem_req  output  1  fetch request to instruction memory.
REQ-005 Port: imem_addr  output  32  fetch address, equal to current PC.
REQ-006 Port: imem_ready  input  1  memory returns imem_rdata for imem_addr this cycle.
REQ-007 Port: imem_rdata  input  32  fetched instruction word.
REQ-008 Port: stall  input  1  decode cannot accept a new instruction; hold IF/ID.
REQ-009 Port: flush  input  1  invalidate IF/ID contents.
REQ-010 Port: redirect_valid  input  1  branch/jump taken; load redirect_pc.
REQ-011 Port: redirect_pc  input  32  target address from execute.
REQ-012 Port: if_id_valid  output  1  IF/ID register holds a live instruction.
REQ-013 Port: if_id_pc  output  32  PC of the held instruction.
REQ-014 Port: if_id_inst  output  32  held instruction, driven to decode and immediate generation.

Function
REQ-015 The FSM SHALL have states FETCH (request outstanding) and HOLD (instruction held, decode stalled).
REQ-016 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; in HOLD, imem_req SHALL be 0.
REQ-017 A capture SHALL occur in FETCH when imem_ready=1 and no redirect, flush, or stall is asserted; the next edge loads if_id_inst=imem_rdata, if_id_pc=PC, if_id_valid=1, PC=PC+4.
REQ-018 Fetch latency SHALL be one cycle from imem_ready to if_id_valid when memory is ready.
REQ-019 While imem_ready=0 in FETCH, PC SHALL hold, imem_req SHALL stay 1, and if_id_* SHALL hold.
REQ-020 stall=1 with if_id_valid=1 SHALL hold if_id_*, PC, and any returned data, and SHALL move FETCH to HOLD; stall=1 with if_id_valid=0 SHALL be ignored.
REQ-021 HOLD SHALL return to FETCH on the first edge with stall=0, without capturing in that edge.
REQ-022 redirect_valid=1 SHALL, on the next edge, set PC=redirect_pc, clear if_id_valid, discard imem_rdata that cycle, and enter FETCH from either state.
REQ-023 flush=1 without redirect SHALL clear if_id_valid, keep PC, discard imem_rdata that cycle, and enter FETCH.
REQ-024 Priority SHALL be: reset > redirect_valid > flush > stall > capture.
REQ-025 PC+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC increments to 32'h0000_0000.
REQ-026 if_id_inst and if_id_pc SHALL retain their last values when if_id_valid is cleared.

Reset
REQ-027 Asserting reset SHALL immediately set PC=RESET_PC, state=FETCH, if_id_valid=0, if_id_pc=0, if_id_inst=32'h0000_0013 (NOP), independent of clk.
REQ-028 While reset=1, imem_req SHALL be 0.
REQ-029 After reset deasserts, the first request SHALL issue at RESET_PC with imem_req=1 on the first cycle.
REQ-030 Reset mid-fetch SHALL discard the outstanding request; no data SHALL be captured.

Configuration
REQ-031 With FETCH_ALIGN_CHECK_EN defined, the block SHALL add output misaligned_fault (1 bit).
REQ-032 misaligned_fault SHALL set on a redirect with redirect_pc[1:0]!=0 and clear on reset or the next valid aligned redirect.
REQ-033 While misaligned_fault=1, imem_req SHALL be 0 and no capture SHALL occur.
REQ-034 Without FETCH_ALIGN_CHECK_EN, misaligned_fault SHALL be absent, and redirect_pc[1:0] SHALL be forced to 0 when loaded.

Structure
REQ-035 The FSM state encoding, NOP constant 32'h0000_0013, and PC increment constant 4 SHALL live in the shared opcodes/constants include, alongside existing opcode macros.
REQ-036 A sub-module pc_register, holding PC with async reset and a load/increment select, SHALL be instantiated; all other logic SHALL be in fetch_stage.

Verification
REQ-037 Reset release with RESET_PC=0 and imem_ready=1 with rdata=32'h00500093 -> next edge: if_id_valid=1, if_id_pc=0, if_id_inst=32'h00500093, imem_addr=4.
REQ-038 imem_ready=0 for 3 cycles at PC=8 -> imem_addr stays 8, imem_req stays 1, if_id_* unchanged; capture occurs on the edge after ready=1.
REQ-039 stall=1 for 2 cycles with valid instruction at PC=4 -> if_id_pc stays 4, imem_req=0 in HOLD; after stall drops, the next fetch is at 8.
REQ-040 redirect_valid=1 with redirect_pc=32'h100 while stall=1 and imem_ready=1 -> if_id_valid=0, imem_addr=32'h100; returned data is discarded.
REQ-041 PC=32'hFFFF_FFFC with capture -> imem_addr=0 on the next cycle; flush in the same cycle as ready -> if_id_valid=0 and PC unchanged.
REQ-042 With FETCH_ALIGN_CHECK_EN, redirect to 32'h102 -> misaligned_fault=1 and imem_req=0; a subsequent redirect to 32'h200 -> fault clears and fetch resumes at 32'h200.
